eth_unpack: RTL and testbench
=============================

Name: eth_unpack

Overview:
- Receive-side counterpart of the Ethernet frame packer: consumes decoded Ethernet frames (header fields plus byte-wide payload AXIS) from the MAC/eth_axis_rx path.
- Validates ethertype and destination MAC, then checks and strips the fixed 20-byte sequence header (byte i == i).
- Forwards exactly PAYLOAD_LEN payload bytes to a byte-wide AXIS FIFO write port with tlast/tuser marking; malformed frames are dropped or flagged.

Parameters:
- HDR_LEN, 20, bytes of sequence header; byte i must equal i[7:0].
- PAYLOAD_LEN, 512, payload bytes forwarded per frame; range 1..65535.
- ETH_TYPE, 16'h0800, required ethertype.
- LOCAL_MAC, 48'h02_00_00_00_00_00, accepted destination MAC; 48'hFF_FF_FF_FF_FF_FF is also accepted.
- CHECK_DEST_MAC, 1, 0 disables destination MAC filtering.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_eth_hdr_valid  in  1  header valid.
- s_eth_hdr_ready  out  1  header ready.
- s_eth_dest_mac  in  48  destination MAC.
- s_eth_src_mac  in  48  source MAC, captured only.
- s_eth_type  in  16  ethertype.
- s_eth_payload_axis_tdata  in  8  frame payload byte.
- s_eth_payload_axis_tvalid  in  1  payload valid.
- s_eth_payload_axis_tready  out  1  payload ready.
- s_eth_payload_axis_tlast  in  1  last frame byte.
- s_eth_payload_axis_tuser  in  1  bad-frame flag, sampled with tlast.
- m_fifo_axis_tdata  out  8  payload byte to FIFO.
- m_fifo_axis_tvalid  out  1  valid.
- m_fifo_axis_tready  in  1  FIFO ready.
- m_fifo_axis_tlast  out  1  last payload byte of block.
- m_fifo_axis_tuser  out  1  block corrupt, valid with tlast.
- m_src_mac  out  48  source MAC of the last accepted frame.
- busy  out  1  state != IDLE.
- error_bad_type  out  1  one-cycle pulse.
- error_bad_header  out  1  one-cycle pulse.
- error_length  out  1  one-cycle pulse.
- frame_count  out  16  good frames delivered; wraps at 65535 to 0.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: all ready, valid, error and busy outputs 0; frame_count 0; m_src_mac 0; m_fifo_axis_tdata/tlast/tuser 0; state IDLE; skid buffer empty.
- Reset mid-frame: return to IDLE, discard buffered bytes, no tlast emitted. Upstream frame remainder is then handled as a new frame, since IDLE does not accept payload.
- States: IDLE, READ_HEADER, READ_PAYLOAD, DROP.
- IDLE:
  - s_eth_hdr_ready=1; payload tready=0.
  - On hdr handshake: if s_eth_type==ETH_TYPE and the MAC passes (CHECK_DEST_MAC==0, dest==LOCAL_MAC, or broadcast), latch m_src_mac, clear hdr_ptr, go to READ_HEADER.
  - Otherwise pulse error_bad_type and go to DROP.
- READ_HEADER:
  - tready=1; each accepted byte is compared to hdr_ptr[7:0]; nothing is forwarded.
  - Mismatch: pulse error_bad_header; go to DROP, or to IDLE if that byte has tlast.
  - tlast on a matching byte before HDR_LEN bytes: pulse error_length, go to IDLE.
  - Byte HDR_LEN-1 matching without tlast: go to READ_PAYLOAD with word_count=PAYLOAD_LEN.
- READ_PAYLOAD:
  - tready = registered early-ready of the 2-entry output skid buffer.
  - Each accepted byte is pushed to the output and word_count decrements.
  - Throughput is 1 byte/cycle when m_fifo_axis_tready=1; latency is 1 cycle from accept to m_fifo_axis_tvalid.
  - Byte with word_count==1 gets m tlast=1. If s tlast is also set: m tuser=s tuser; frame_count++ only if s tuser=0; go to IDLE.
  - word_count==1 without s tlast: frame too long; tlast emitted with tuser=1; pulse error_length; go to DROP.
  - s tlast with word_count>1: frame too short; that byte goes out with tlast=1, tuser=1; pulse error_length; go to IDLE.
- DROP: tready=1, discard bytes; on tlast go to IDLE; no output.
- Error pulse timing: pulses fire the cycle after the triggering handshake.
- frame_count width rule: frame_count is 16-bit modulo.
- Skid buffer: m_fifo_axis_tvalid never drops without a handshake; tdata/tlast/tuser are stable while valid && !ready.

Test Plan:
- Good frame (type 0x0800, dest LOCAL_MAC, header 0..19, 512 bytes 0xA5 with tlast on the last one), m_fifo_axis_tready=1 -> exactly 512 bytes 0xA5 out, tlast on the 512th, tuser=0, frame_count=1, no error pulses.
- Ethertype 0x0806 with a 600-byte payload -> error_bad_type pulses once; payload fully consumed; no m_fifo_axis_tvalid; back in IDLE; a following good frame delivered normally.
- Header byte 5 = 0x55 -> error_bad_header pulse, frame dropped to tlast, zero output bytes.
- Short frame, tlast on payload byte 100 -> 100 bytes out, the 100th with tlast=1/tuser=1, error_length pulse, frame_count unchanged.
- Long frame of 520 payload bytes -> 512 out, tlast+tuser on the 512th, error_length pulse, 8 excess bytes discarded.
- Random 50% m_fifo_axis_tready backpressure on a good frame, then rst asserted at payload byte 300 of a second frame -> first frame's 512 bytes intact and in order; after reset all outputs are at reset values; next good frame delivered correctly.

Source files
------------

// File: rtl/eth_unpack.sv
// Receive-side Ethernet frame unpacker: validates type/MAC, strips the 0..HDR_LEN-1
// sequence header and forwards PAYLOAD_LEN bytes through a 2-entry output skid buffer.
module eth_unpack #(
  parameter int          HDR_LEN        = 20,
  parameter int          PAYLOAD_LEN    = 512,
  parameter logic [15:0] ETH_TYPE       = 16'h0800,
  parameter logic [47:0] LOCAL_MAC      = 48'h02_00_00_00_00_00,
  parameter bit          CHECK_DEST_MAC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_fifo_axis_tdata,
  output logic        m_fifo_axis_tvalid,
  input  logic        m_fifo_axis_tready,
  output logic        m_fifo_axis_tlast,
  output logic        m_fifo_axis_tuser,
  output logic [47:0] m_src_mac,
  output logic        busy,
  output logic        error_bad_type,
  output logic        error_bad_header,
  output logic        error_length,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, READ_HEADER, READ_PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  state_t      state, state_nxt;
  logic [15:0] hdr_ptr, word_count;
  logic        hdr_rdy, pl_rdy;
  logic        push, pop;
  beat_t       push_beat;
  logic        set_bt, set_bh, set_bl;
  logic        inc_fc, latch_mac, inc_ptr, ld_wc;
  logic        mac_ok;

  beat_t       buf_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  cnt, cnt_nxt;
  logic        fifo_rdy_q;

  assign mac_ok = !CHECK_DEST_MAC || (s_eth_dest_mac == LOCAL_MAC) ||
                  (s_eth_dest_mac == 48'hFF_FF_FF_FF_FF_FF);

  // Readies are masked during reset so they read 0 while rst is held.
  assign s_eth_hdr_ready           = hdr_rdy && !rst;
  assign s_eth_payload_axis_tready = pl_rdy && !rst;
  assign busy                      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hdr_rdy   = 1'b0;
    pl_rdy    = 1'b0;
    push      = 1'b0;
    push_beat = '0;
    set_bt    = 1'b0;
    set_bh    = 1'b0;
    set_bl    = 1'b0;
    inc_fc    = 1'b0;
    latch_mac = 1'b0;
    inc_ptr   = 1'b0;
    ld_wc     = 1'b0;
    case (state)
      IDLE: begin
        hdr_rdy = 1'b1;
        if (s_eth_hdr_valid) begin
          if ((s_eth_type == ETH_TYPE) && mac_ok) begin
            latch_mac = 1'b1;
            state_nxt = READ_HEADER;
          end else begin
            set_bt    = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      READ_HEADER: begin
        pl_rdy = 1'b1;
        if (s_eth_payload_axis_tvalid) begin
          if (s_eth_payload_axis_tdata != hdr_ptr[7:0]) begin
            set_bh    = 1'b1;
            state_nxt = s_eth_payload_axis_tlast ? IDLE : DROP;
          end else if (s_eth_payload_axis_tlast) begin
            set_bl    = 1'b1;
            state_nxt = IDLE;
          end else if (hdr_ptr == 16'(HDR_LEN - 1)) begin
            ld_wc     = 1'b1;
            state_nxt = READ_PAYLOAD;
          end else begin
            inc_ptr = 1'b1;
          end
        end
      end
      READ_PAYLOAD: begin
        pl_rdy = fifo_rdy_q;
        if (s_eth_payload_axis_tvalid && fifo_rdy_q) begin
          push           = 1'b1;
          push_beat.data = s_eth_payload_axis_tdata;
          if (word_count == 16'd1) begin
            push_beat.last = 1'b1;
            if (s_eth_payload_axis_tlast) begin
              push_beat.user = s_eth_payload_axis_tuser;
              inc_fc         = !s_eth_payload_axis_tuser;
              state_nxt      = IDLE;
            end else begin
              // Too long: close the block as corrupt and discard the excess.
              push_beat.user = 1'b1;
              set_bl         = 1'b1;
              state_nxt      = DROP;
            end
          end else if (s_eth_payload_axis_tlast) begin
            push_beat.last = 1'b1;
            push_beat.user = 1'b1;
            set_bl         = 1'b1;
            state_nxt      = IDLE;
          end
        end
      end
      DROP: begin
        pl_rdy = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_ptr          <= '0;
      word_count       <= '0;
      m_src_mac        <= '0;
      frame_count      <= '0;
      error_bad_type   <= 1'b0;
      error_bad_header <= 1'b0;
      error_length     <= 1'b0;
    end else begin
      error_bad_type   <= set_bt;
      error_bad_header <= set_bh;
      error_length     <= set_bl;
      if (latch_mac) m_src_mac <= s_eth_src_mac;
      if (latch_mac)    hdr_ptr <= '0;
      else if (inc_ptr) hdr_ptr <= hdr_ptr + 16'd1;
      if (ld_wc)     word_count <= 16'(PAYLOAD_LEN);
      else if (push) word_count <= word_count - 16'd1;
      if (inc_fc) frame_count <= frame_count + 16'd1;
    end
  end

  // Output skid buffer: ready is registered from the next occupancy, so one
  // free slot is always guaranteed for a byte accepted under that ready.
  assign m_fifo_axis_tvalid = (cnt != 2'd0);
  assign pop                = m_fifo_axis_tvalid && m_fifo_axis_tready;
  assign cnt_nxt            = 2'(cnt + {1'b0, push} - {1'b0, pop});
  assign m_fifo_axis_tdata  = buf_mem[rd_ptr].data;
  assign m_fifo_axis_tlast  = buf_mem[rd_ptr].last;
  assign m_fifo_axis_tuser  = buf_mem[rd_ptr].user;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      fifo_rdy_q <= 1'b0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= push_beat;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt        <= cnt_nxt;
      fifo_rdy_q <= (cnt_nxt < 2'd2);
    end
  end

endmodule

// File: tb/tb_eth_unpack.sv
// Bench for eth_unpack: fixed-expectation frame table, randomized frames against a
// frame-level reference model, and a backpressure plus mid-frame reset sequence.
module tb_eth_unpack;
  localparam int          HDR_LEN = 20;
  localparam int          PL      = 512;
  localparam int          TO      = 5000;
  localparam logic [47:0] LMAC    = 48'h02_00_00_00_00_00;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  typedef logic [7:0] bq_t [$];
  typedef logic [9:0] oq_t [$];

  logic clk = 1'b0, rst = 1'b1;
  logic s_eth_hdr_valid = 1'b0, s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0, s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic [47:0] m_src_mac;
  logic busy, err_bt, err_bh, err_bl;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  eth_unpack dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready), .s_eth_payload_axis_tlast(s_tlast),
    .s_eth_payload_axis_tuser(s_tuser),
    .m_fifo_axis_tdata(m_tdata), .m_fifo_axis_tvalid(m_tvalid), .m_fifo_axis_tready(m_tready),
    .m_fifo_axis_tlast(m_tlast), .m_fifo_axis_tuser(m_tuser),
    .m_src_mac(m_src_mac), .busy(busy),
    .error_bad_type(err_bt), .error_bad_header(err_bh), .error_length(err_bl),
    .frame_count(frame_count)
  );

  int pass_cnt = 0, total_cnt = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Output monitor, error-pulse counters and skid-stability watch, sampled at negedge.
  oq_t got_q;
  int n_bt = 0, n_bh = 0, n_bl = 0, stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      got_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || {m_tdata, m_tlast, m_tuser} != prev_beat)) stall_viol++;
      if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tlast, m_tuser});
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tlast, m_tuser};
      n_bt += int'(err_bt);
      n_bh += int'(err_bh);
      n_bl += int'(err_bl);
    end
  end

  bit bp_en = 1'b0, gaps = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_frame(input logic [15:0] ty, input logic [47:0] dst, input logic [47:0] src,
                            input bq_t b, input logic usr, input int abort_at);
    int  t;
    bit  r;
    s_eth_type = ty; s_eth_dest_mac = dst; s_eth_src_mac = src; s_eth_hdr_valid = 1'b1;
    t = 0;
    r = 1'b0;
    while (!r) begin
      @(negedge clk); r = s_eth_hdr_ready;
      @(posedge clk); #1;
      if (!r && ++t > TO) begin
        chk("hdr handshake timeout", 0, 1);
        s_eth_hdr_valid = 1'b0;
        return;
      end
    end
    s_eth_hdr_valid = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (i == abort_at) begin
        s_tvalid = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata = b[i]; s_tlast = (i == b.size() - 1); s_tuser = s_tlast ? usr : 1'b0;
      s_tvalid = 1'b1;
      t = 0;
      r = 1'b0;
      while (!r) begin
        @(negedge clk); r = s_tready;
        @(posedge clk); #1;
        if (!r && ++t > TO) begin
          chk("payload handshake timeout", 0, 1);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || m_tvalid) && t < TO);
    if (t >= TO) chk("drain timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk(input int hlen, input int bad, input int plen, input bit rnd);
    bq_t q;
    for (int i = 0; i < hlen; i++) q.push_back(i == bad ? 8'h55 : 8'(i));
    for (int k = 0; k < plen; k++) q.push_back(rnd ? 8'($urandom) : 8'hA5);
    return q;
  endfunction

  // Frame-level reference: what the block should emit for one whole frame.
  task automatic model(input logic [15:0] ty, input logic [47:0] dst, input bq_t b, input logic usr,
                       output oq_t exp, output int ebt, output int ebh, output int ebl, output int fci);
    int n, m;
    bit lst, usr_o;
    exp.delete(); ebt = 0; ebh = 0; ebl = 0; fci = 0;
    if (ty != 16'h0800 || !(dst == LMAC || dst == BCAST)) begin ebt = 1; return; end
    for (int i = 0; i < HDR_LEN; i++) begin
      if (b[i] != 8'(i)) begin ebh = 1; return; end
      if (i == b.size() - 1) begin ebl = 1; return; end
    end
    n = b.size() - HDR_LEN;
    m = (n < PL) ? n : PL;
    for (int k = 0; k < m; k++) begin
      lst   = (k == m - 1);
      usr_o = lst && ((n != PL) || usr);
      exp.push_back({b[HDR_LEN + k], lst, usr_o});
    end
    if (n != PL) ebl = 1;
    else if (!usr) fci = 1;
  endtask

  task automatic run_frame(input logic [15:0] ty, input logic [47:0] dst, input logic [47:0] src,
                           input bq_t b, input logic usr, input int abort_at,
                           output oq_t got, output int dbt, output int dbh, output int dbl,
                           output int dfc);
    int bt0, bh0, bl0;
    logic [15:0] fc0;
    got_q.delete();
    bt0 = n_bt; bh0 = n_bh; bl0 = n_bl; fc0 = frame_count;
    send_frame(ty, dst, src, b, usr, abort_at);
    if (abort_at < 0) wait_idle();
    got = got_q;
    dbt = n_bt - bt0; dbh = n_bh - bh0; dbl = n_bl - bl0;
    dfc = int'(16'(frame_count - fc0));
  endtask

  function automatic int diff_cnt(input oq_t a, input oq_t e);
    int d = (a.size() > e.size()) ? a.size() - e.size() : e.size() - a.size();
    for (int i = 0; i < a.size() && i < e.size(); i++) if (a[i] != e[i]) d++;
    return d;
  endfunction

  typedef struct {
    logic [15:0] ty;
    logic [47:0] dst;
    int hlen, bad, plen;
    logic usr;
    int nb, bt, bh, bl, fc;
    logic luser;
  } vec_t;
  vec_t tbl[11];

  task automatic check_reset(input string tag);
    chk({tag, " hdr_ready"}, s_eth_hdr_ready, 0);
    chk({tag, " pl_tready"}, s_tready, 0);
    chk({tag, " m_tvalid"}, m_tvalid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " errors"}, {err_bt, err_bh, err_bl}, 0);
    chk({tag, " frame_count"}, frame_count, 0);
    chk({tag, " m_src_mac"}, m_src_mac, 0);
    chk({tag, " m_data/last/user"}, {m_tdata, m_tlast, m_tuser}, 0);
  endtask

  initial begin
    oq_t got, exp;
    bq_t b;
    int dbt, dbh, dbl, dfc, ebt, ebh, ebl, efc, bad_beats, kind, plen, bad;
    logic usr;
    logic [47:0] src;

    //        type      dest     hlen bad plen usr  nb  bt bh bl fc luser
    tbl[0]  = '{16'h0800, LMAC,  20, -1, 512, 0, 512, 0, 0, 0, 1, 1'b0};
    tbl[1]  = '{16'h0806, LMAC,  20, -1, 600, 0,   0, 1, 0, 0, 0, 1'b0};
    tbl[2]  = '{16'h0800, LMAC,  20, -1, 512, 0, 512, 0, 0, 0, 1, 1'b0};
    tbl[3]  = '{16'h0800, LMAC,  20,  5, 512, 0,   0, 0, 1, 0, 0, 1'b0};
    tbl[4]  = '{16'h0800, LMAC,  20, -1, 100, 0, 100, 0, 0, 1, 0, 1'b1};
    tbl[5]  = '{16'h0800, LMAC,  20, -1, 520, 0, 512, 0, 0, 1, 0, 1'b1};
    tbl[6]  = '{16'h0800, BCAST, 20, -1, 512, 0, 512, 0, 0, 0, 1, 1'b0};
    tbl[7]  = '{16'h0800, 48'h02_00_00_00_00_01, 20, -1, 64, 0, 0, 1, 0, 0, 0, 1'b0};
    tbl[8]  = '{16'h0800, LMAC,  20, -1, 512, 1, 512, 0, 0, 0, 0, 1'b1};
    tbl[9]  = '{16'h0800, LMAC,   8, -1,   0, 0,   0, 0, 0, 1, 0, 1'b0};
    tbl[10] = '{16'h0800, LMAC,  20, -1,   1, 0,   1, 0, 0, 1, 0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    foreach (tbl[r]) begin
      src = {16'h0ABC, 32'(r)};
      b = mk(tbl[r].hlen, tbl[r].bad, tbl[r].plen, 1'b0);
      run_frame(tbl[r].ty, tbl[r].dst, src, b, tbl[r].usr, -1, got, dbt, dbh, dbl, dfc);
      chk($sformatf("row%0d nbytes", r), got.size(), tbl[r].nb);
      chk($sformatf("row%0d bad_type", r), dbt, tbl[r].bt);
      chk($sformatf("row%0d bad_header", r), dbh, tbl[r].bh);
      chk($sformatf("row%0d length", r), dbl, tbl[r].bl);
      chk($sformatf("row%0d frame_count delta", r), dfc, tbl[r].fc);
      if (tbl[r].bt == 0) chk($sformatf("row%0d src_mac", r), m_src_mac, src);
      if (got.size() > 0) begin
        chk($sformatf("row%0d last tlast", r), got[got.size()-1][1], 1);
        chk($sformatf("row%0d last tuser", r), got[got.size()-1][0], tbl[r].luser);
        bad_beats = 0;
        for (int i = 0; i < got.size(); i++)
          if (got[i][9:2] != 8'hA5 || got[i][1] != (i == got.size() - 1) ||
              (i != got.size() - 1 && got[i][0])) bad_beats++;
        chk($sformatf("row%0d beat contents", r), bad_beats, 0);
      end
    end

    bp_en = 1'b1;
    gaps  = 1'b1;
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 5);
      plen = PL; bad = -1; usr = 1'b0;
      case (kind)
        2: ;
        3: bad = $urandom_range(0, HDR_LEN - 1);
        4: plen = $urandom_range(1, PL - 1);
        5: plen = $urandom_range(PL + 1, PL + 18);
        default: usr = ($urandom_range(0, 3) == 0);
      endcase
      b = mk(HDR_LEN, bad, plen, 1'b1);
      src = {16'h0DEF, 32'($urandom)};
      model(kind == 2 ? 16'h86DD : 16'h0800, LMAC, b, usr, exp, ebt, ebh, ebl, efc);
      run_frame(kind == 2 ? 16'h86DD : 16'h0800, LMAC, src, b, usr, -1, got, dbt, dbh, dbl, dfc);
      chk($sformatf("rnd%0d beats vs model", f), diff_cnt(got, exp), 0);
      chk($sformatf("rnd%0d errors", f), {dbt, dbh, dbl}, {ebt, ebh, ebl});
      chk($sformatf("rnd%0d frame_count delta", f), dfc, efc);
    end

    gaps = 1'b0;
    b = mk(HDR_LEN, -1, PL, 1'b1);
    model(16'h0800, LMAC, b, 1'b0, exp, ebt, ebh, ebl, efc);
    run_frame(16'h0800, LMAC, 48'h1, b, 1'b0, -1, got, dbt, dbh, dbl, dfc);
    chk("bp frame beats vs model", diff_cnt(got, exp), 0);
    chk("bp frame frame_count delta", dfc, 1);
    b = mk(HDR_LEN, -1, PL, 1'b1);
    run_frame(16'h0800, LMAC, 48'h2, b, 1'b0, HDR_LEN + 300, got, dbt, dbh, dbl, dfc);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("mid-frame reset");
    @(posedge clk); #1;
    rst = 1'b0;
    bp_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    b = mk(HDR_LEN, -1, PL, 1'b1);
    model(16'h0800, LMAC, b, 1'b0, exp, ebt, ebh, ebl, efc);
    run_frame(16'h0800, LMAC, 48'h3, b, 1'b0, -1, got, dbt, dbh, dbl, dfc);
    chk("post-reset beats vs model", diff_cnt(got, exp), 0);
    chk("post-reset frame_count", frame_count, 1);
    chk("post-reset errors", {dbt, dbh, dbl}, 0);
    chk("skid stability under stall", stall_viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
